// File: rtl/mcb_cmd_out.sv
// SDR SDRAM command issue stage: encodes init requests, runs periodic auto-refresh and
// issues host row/column commands onto registered SDRAM command/address pins.
module mcb_cmd_out #(
  parameter int unsigned             ADDR_W    = 13,
  parameter int unsigned             BA_W      = 2,
  parameter logic [ADDR_W-1:0]       MODE_REG  = 13'h0033,
  parameter int unsigned             REF_INT   = 1560,
  parameter int unsigned             REF_INT_W = 11,
  parameter int unsigned             TRP       = 3,
  parameter int unsigned             TRFC      = 9,
  parameter int unsigned             CMD_GAP   = 1
) (
  input  logic              mcb_clk,
  input  logic              mcb_rst_n,
  input  logic              mcb_sclr_n,
  input  logic              i_prea,
  input  logic              i_ref,
  input  logic              i_lmr,
  input  logic              i_ready,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [BA_W-1:0]   cmd_ba,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              ref_busy,
  output logic              ref_ovf,
  output logic              sd_cs_n,
  output logic              sd_ras_n,
  output logic              sd_cas_n,
  output logic              sd_we_n,
  output logic [BA_W-1:0]   sd_ba,
  output logic [ADDR_W-1:0] sd_addr
);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;

  localparam logic [ADDR_W-1:0] ADDR_A10 = ADDR_W'(1) << 10;

  localparam int unsigned TMR_MAX0 = (TRP > TRFC) ? TRP : TRFC;
  localparam int unsigned TMR_MAX  = (TMR_MAX0 > CMD_GAP) ? TMR_MAX0 : CMD_GAP;
  localparam int unsigned TMR_W    = $clog2(TMR_MAX + 2);

  localparam logic [TMR_W-1:0]     TRP_LD   = TMR_W'(TRP - 1);
  localparam logic [TMR_W-1:0]     TRFC_LD  = TMR_W'(TRFC - 1);
  localparam logic [TMR_W-1:0]     GAP_LD   = TMR_W'((CMD_GAP > 0) ? CMD_GAP - 1 : 0);
  localparam logic [REF_INT_W-1:0] REF_LAST = REF_INT_W'(REF_INT - 1);

  typedef enum logic [2:0] {
    StInit,
    StRdy,
    StGap,
    StRpre,
    StRpreW,
    StRref,
    StRrefW
  } state_e;

  state_e                r_state;
  logic [TMR_W-1:0]      r_tmr;
  logic [3:0]            r_cmd;
  logic [BA_W-1:0]       r_ba;
  logic [ADDR_W-1:0]     r_addr;
  logic [REF_INT_W-1:0]  r_ref_cnt;
  logic                  r_ref_pend;
  logic                  r_ref_ovf;

  logic                  w_wrap;
  logic                  w_pend_clr;
  logic                  w_accept;
  logic [3:0]            w_host_cmd;

  assign w_wrap     = (r_state != StInit) && (r_ref_cnt == REF_LAST);
  assign w_pend_clr = (r_state == StRref);
  assign cmd_ready  = (r_state == StRdy) && !r_ref_pend;
  assign w_accept   = cmd_valid && cmd_ready;
  assign ref_busy   = (r_state == StRpre) || (r_state == StRpreW) ||
                      (r_state == StRref) || (r_state == StRrefW);
  assign ref_ovf    = r_ref_ovf;

  always_comb begin
    w_host_cmd = CMD_NOP;
    case (cmd_type)
      2'b00:   w_host_cmd = CMD_ACT;
      2'b01:   w_host_cmd = CMD_READ;
      2'b10:   w_host_cmd = CMD_WRITE;
      default: w_host_cmd = CMD_PRE;
    endcase
  end

  // Refresh interval timer; a wrap coinciding with the RREF clear keeps the new request pending.
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b0;
      r_ref_ovf  <= 1'b0;
    end else if (!mcb_sclr_n) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b0;
      r_ref_ovf  <= 1'b0;
    end else begin
      if (r_state == StInit || w_wrap) begin
        r_ref_cnt <= '0;
      end else begin
        r_ref_cnt <= r_ref_cnt + REF_INT_W'(1);
      end
      if (w_wrap) begin
        r_ref_pend <= 1'b1;
        if (r_ref_pend && !w_pend_clr) begin
          r_ref_ovf <= 1'b1;
        end
      end else if (w_pend_clr) begin
        r_ref_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      r_state <= StInit;
      r_tmr   <= '0;
      r_cmd   <= CMD_DESEL;
      r_ba    <= '0;
      r_addr  <= '0;
    end else if (!mcb_sclr_n) begin
      r_state <= StInit;
      r_tmr   <= '0;
      r_cmd   <= CMD_DESEL;
      r_ba    <= '0;
      r_addr  <= '0;
    end else begin
      r_cmd  <= CMD_NOP;
      r_ba   <= '0;
      r_addr <= '0;
      unique case (r_state)
        StInit: begin
          if (i_prea) begin
            r_cmd  <= CMD_PRE;
            r_addr <= ADDR_A10;
          end else if (i_ref) begin
            r_cmd  <= CMD_REF;
          end else if (i_lmr) begin
            r_cmd  <= CMD_LMR;
            r_addr <= MODE_REG;
          end
          if (i_ready) begin
            r_state <= StRdy;
          end
        end
        StRdy: begin
          if (r_ref_pend) begin
            r_state <= StRpre;
          end else if (w_accept) begin
            r_cmd  <= w_host_cmd;
            r_ba   <= cmd_ba;
            r_addr <= cmd_addr;
            if (CMD_GAP > 0) begin
              r_state <= StGap;
              r_tmr   <= GAP_LD;
            end
          end
        end
        StGap: begin
          if (r_tmr == '0) begin
            r_state <= StRdy;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        StRpre: begin
          r_cmd   <= CMD_PRE;
          r_addr  <= ADDR_A10;
          r_state <= StRpreW;
          r_tmr   <= TRP_LD;
        end
        StRpreW: begin
          if (r_tmr == '0) begin
            r_state <= StRref;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        StRref: begin
          r_cmd   <= CMD_REF;
          r_state <= StRrefW;
          r_tmr   <= TRFC_LD;
        end
        StRrefW: begin
          if (r_tmr == '0) begin
            r_state <= StRdy;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        default: r_state <= StInit;
      endcase
    end
  end

  assign sd_cs_n  = r_cmd[3];
  assign sd_ras_n = r_cmd[2];
  assign sd_cas_n = r_cmd[1];
  assign sd_we_n  = r_cmd[0];
  assign sd_ba    = r_ba;
  assign sd_addr  = r_addr;

endmodule

// File: tb/tb_mcb_cmd_out.sv
// Directed bench for mcb_cmd_out: init encoding, host handshake, refresh, overflow and clear.
module tb_mcb_cmd_out;

  localparam logic [3:0] P_DESEL = 4'b1111;
  localparam logic [3:0] P_NOP   = 4'b0111;
  localparam logic [3:0] P_ACT   = 4'b0011;
  localparam logic [3:0] P_RD    = 4'b0101;
  localparam logic [3:0] P_WR    = 4'b0100;
  localparam logic [3:0] P_PRE   = 4'b0010;
  localparam logic [3:0] P_REF   = 4'b0001;
  localparam logic [3:0] P_LMR   = 4'b0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sclr_n, prea, refr, lmr, ready, cmd_valid;
  logic [1:0]  cmd_type, cmd_ba;
  logic [12:0] cmd_addr;

  logic        a_cmd_ready, a_busy, a_ovf, a_cs_n, a_ras_n, a_cas_n, a_we_n;
  logic [1:0]  a_ba;
  logic [12:0] a_addr;
  logic        b_cmd_ready, b_busy, b_ovf, b_cs_n, b_ras_n, b_cas_n, b_we_n;
  logic [1:0]  b_ba;
  logic [12:0] b_addr;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] pk(input logic [3:0] c, input logic [1:0] ba,
                                     input logic [12:0] a);
    return {6'b0, a, ba, 7'b0, c};
  endfunction

  logic [31:0] a_pins;
  assign a_pins = pk({a_cs_n, a_ras_n, a_cas_n, a_we_n}, a_ba, a_addr);

  mcb_cmd_out #(
    .REF_INT(20), .REF_INT_W(11), .TRP(3), .TRFC(9), .CMD_GAP(1)
  ) dut (
    .mcb_clk(clk), .mcb_rst_n(rst_n), .mcb_sclr_n(sclr_n),
    .i_prea(prea), .i_ref(refr), .i_lmr(lmr), .i_ready(ready),
    .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_type(cmd_type),
    .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .ref_busy(a_busy), .ref_ovf(a_ovf),
    .sd_cs_n(a_cs_n), .sd_ras_n(a_ras_n), .sd_cas_n(a_cas_n), .sd_we_n(a_we_n),
    .sd_ba(a_ba), .sd_addr(a_addr)
  );

  // Short interval so a second expiry lands while the first refresh is still pending.
  mcb_cmd_out #(
    .REF_INT(4), .REF_INT_W(11), .TRP(3), .TRFC(9), .CMD_GAP(1)
  ) dut_ovf (
    .mcb_clk(clk), .mcb_rst_n(rst_n), .mcb_sclr_n(sclr_n),
    .i_prea(prea), .i_ref(refr), .i_lmr(lmr), .i_ready(ready),
    .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd_type(cmd_type),
    .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .ref_busy(b_busy), .ref_ovf(b_ovf),
    .sd_cs_n(b_cs_n), .sd_ras_n(b_ras_n), .sd_cas_n(b_cas_n), .sd_we_n(b_we_n),
    .sd_ba(b_ba), .sd_addr(b_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_init(input logic p, input logic r, input logic l,
                            input logic [31:0] exp, input string tag);
    prea = p;
    refr = r;
    lmr  = l;
    tick();
    prea = 1'b0;
    refr = 1'b0;
    lmr  = 1'b0;
    check(tag, a_pins, exp);
    tick();
    check({tag, " nop"}, a_pins, pk(P_NOP, 2'd0, 13'h0));
  endtask

  initial begin
    logic [31:0] exp_pins;
    rst_n = 1'b0; sclr_n = 1'b1; prea = 1'b0; refr = 1'b0; lmr = 1'b0; ready = 1'b0;
    cmd_valid = 1'b0; cmd_type = 2'd0; cmd_ba = 2'd0; cmd_addr = 13'h0;
    tick();
    tick();
    check("rst pins", a_pins, pk(P_DESEL, 2'd0, 13'h0));
    check("rst cmd_ready", a_cmd_ready, 1'b0);
    check("rst ref_busy", a_busy, 1'b0);
    check("rst ref_ovf", a_ovf, 1'b0);
    rst_n = 1'b1;
    tick();
    check("init idle", a_pins, pk(P_NOP, 2'd0, 13'h0));

    pulse_init(1'b1, 1'b0, 1'b0, pk(P_PRE, 2'd0, 13'h0400), "init pre");
    pulse_init(1'b0, 1'b1, 1'b0, pk(P_REF, 2'd0, 13'h0000), "init ref1");
    pulse_init(1'b0, 1'b1, 1'b0, pk(P_REF, 2'd0, 13'h0000), "init ref2");
    pulse_init(1'b0, 1'b0, 1'b1, pk(P_LMR, 2'd0, 13'h0033), "init lmr");
    pulse_init(1'b1, 1'b1, 1'b1, pk(P_PRE, 2'd0, 13'h0400), "prio pre");
    pulse_init(1'b0, 1'b1, 1'b1, pk(P_REF, 2'd0, 13'h0000), "prio ref");
    check("init cmd_ready", a_cmd_ready, 1'b0);

    // R0: first RDY cycle, refresh counter at 0
    ready = 1'b1;
    tick();
    check("rdy cmd_ready", a_cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_type = 2'b00; cmd_ba = 2'd2; cmd_addr = 13'h1ABC;
    tick();
    check("act pins", a_pins, pk(P_ACT, 2'd2, 13'h1ABC));
    check("gap cmd_ready", a_cmd_ready, 1'b0);
    cmd_type = 2'b01; cmd_addr = 13'h0010;
    tick();
    check("post gap nop", a_pins, pk(P_NOP, 2'd0, 13'h0));
    check("post gap cmd_ready", a_cmd_ready, 1'b1);
    tick();
    check("read pins", a_pins, pk(P_RD, 2'd2, 13'h0010));
    cmd_valid = 1'b0;
    tick();
    check("r4 cmd_ready", a_cmd_ready, 1'b1);
    prea = 1'b1;
    tick();
    prea = 1'b0;
    check("prea ignored", a_pins, pk(P_NOP, 2'd0, 13'h0));

    // R5 onward: WRITEs back to back; acceptance at R19 collides with the first wrap.
    cmd_valid = 1'b1; cmd_type = 2'b10; cmd_ba = 2'd1; cmd_addr = 13'h0155;
    for (int c = 6; c <= 48; c++) begin
      if (c == 38) cmd_valid = 1'b0;
      tick();
      if ((c % 2 == 0 && c <= 20) || c == 37) exp_pins = pk(P_WR, 2'd1, 13'h0155);
      else if (c == 23 || c == 42)            exp_pins = pk(P_PRE, 2'd0, 13'h0400);
      else if (c == 27 || c == 46)            exp_pins = pk(P_REF, 2'd0, 13'h0000);
      else                                    exp_pins = pk(P_NOP, 2'd0, 13'h0000);
      check($sformatf("pins c%0d", c), a_pins, exp_pins);
      check($sformatf("cmd_ready c%0d", c), a_cmd_ready,
            (c % 2 == 1 && c >= 7 && c <= 19) || c == 36 || c == 38 || c == 39);
      check($sformatf("ref_busy c%0d", c), a_busy, (c >= 22 && c <= 35) || c >= 41);
      check($sformatf("ovf4 c%0d", c), b_ovf, c >= 8);
    end
    check("no ovf", a_ovf, 1'b0);

    // Clear mid-RREF_W
    sclr_n = 1'b0;
    ready  = 1'b0;
    tick();
    check("clr pins", a_pins, pk(P_DESEL, 2'd0, 13'h0));
    check("clr cmd_ready", a_cmd_ready, 1'b0);
    check("clr ref_busy", a_busy, 1'b0);
    check("clr ovf4", b_ovf, 1'b0);
    sclr_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      check($sformatf("held init pins %0d", i), a_pins, pk(P_NOP, 2'd0, 13'h0));
      check($sformatf("held init busy %0d", i), a_busy | b_busy, 1'b0);
      check($sformatf("held init ready %0d", i), a_cmd_ready, 1'b0);
    end
    check("held ovf4", b_ovf, 1'b0);

    ready = 1'b1;
    for (int s = 0; s <= 22; s++) begin
      tick();
      check($sformatf("restart ready s%0d", s), a_cmd_ready, s <= 19);
      check($sformatf("restart busy s%0d", s), a_busy, s >= 21);
      check($sformatf("restart pins s%0d", s), a_pins,
            (s == 22) ? pk(P_PRE, 2'd0, 13'h0400) : pk(P_NOP, 2'd0, 13'h0));
    end
    check("final no ovf", a_ovf, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
